// File: rtl/accel_pkg.sv
// Shared widths, int8 limits and small helpers for the accelerator datapath.
package accel_pkg;

  localparam int ACC_W    = 32;
  localparam int PIX_W    = 8;
  localparam int MULT_W   = 16;
  localparam int SHIFT_W  = 5;
  localparam int PROD_W   = 49;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  // Position of a sample inside its 2x2 window: {row parity, col parity}.
  typedef enum logic [1:0] {
    POS_TL = 2'b00,
    POS_TR = 2'b01,
    POS_BL = 2'b10,
    POS_BR = 2'b11
  } pool_pos_e;

  function automatic logic signed [PIX_W-1:0] smax(input logic signed [PIX_W-1:0] a,
                                                    input logic signed [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/requant_unit.sv
// Two-stage requantiser: signed multiply, then round-half-up shift and int8 saturate.
// An opaque position tag travels alongside each valid sample.
module requant_unit
  import accel_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  pixel_in,
  input  logic        [MULT_W-1:0] mult,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic        [TAG_W-1:0]  tag_in,
  output logic                     out_valid,
  output logic signed [PIX_W-1:0]  q,
  output logic        [TAG_W-1:0]  tag_out
);

  localparam logic signed [PROD_W:0] SAT_HI = (PROD_W+1)'(INT8_MAX);
  localparam logic signed [PROD_W:0] SAT_LO = (PROD_W+1)'(INT8_MIN);

  logic signed [PROD_W-1:0] a_ext, m_ext, prod;
  logic                     v1;
  logic        [TAG_W-1:0]  tag1;

  logic signed [PROD_W:0]   half, rnd, r;
  logic signed [PIX_W-1:0]  q_n;

  always_comb begin
    a_ext = {{(PROD_W-ACC_W){pixel_in[ACC_W-1]}}, pixel_in};
    m_ext = {{(PROD_W-MULT_W){1'b0}}, mult};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      prod <= '0;
      tag1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        prod <= a_ext * m_ext;
        tag1 <= tag_in;
      end
    end
  end

  // Rounding bias is 2^(shift-1), or nothing when shift is zero; one extra
  // bit of headroom keeps the biased sum from wrapping.
  always_comb begin
    half = '0;
    if (shift != '0) half[shift - 5'd1] = 1'b1;
    rnd = {prod[PROD_W-1], prod} + half;
    r   = rnd >>> shift;
    if (r > SAT_HI)      q_n = PIX_W'(INT8_MAX);
    else if (r < SAT_LO) q_n = PIX_W'(INT8_MIN);
    else                 q_n = r[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      tag_out   <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        q       <= q_n;
        tag_out <= tag1;
      end
    end
  end

endmodule

// File: rtl/requant_pool2x2.sv
// Requantise the accumulator stream to int8 and optionally 2x2/stride-2 max pool it.
// Pooling keeps one horizontal pair max per window in a half-width row buffer.
module requant_pool2x2
  import accel_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [ACC_W-1:0]   pixel_in,
  input  logic                      frame_start,
  input  logic        [7:0]         width,
  input  logic        [MULT_W-1:0]  mult,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      pool_en,
  output logic                      out_valid,
  output logic signed [PIX_W-1:0]   pixel_out
);

  localparam int COL_W  = $clog2(IMAGE_WIDTH);
  localparam int ADDR_W = COL_W - 1;
  localparam int DEPTH  = IMAGE_WIDTH / 2;

  if (IMAGE_WIDTH < 4 || (IMAGE_WIDTH % 2) != 0 || IMAGE_WIDTH > 256 || IMAGE_HEIGHT < 2) begin : g_param_check
    $error("requant_pool2x2: unsupported IMAGE_WIDTH/IMAGE_HEIGHT");
  end

  logic [COL_W-1:0] col, cur_col;
  logic             par, cur_par, last_col;

  always_comb begin
    cur_col  = frame_start ? '0 : col;
    cur_par  = frame_start ? 1'b0 : par;
    last_col = (8'(cur_col) == (width - 8'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      par <= 1'b0;
    end else if (in_valid) begin
      if (last_col) begin
        col <= '0;
        par <= ~cur_par;
      end else begin
        col <= cur_col + COL_W'(1);
        par <= cur_par;
      end
    end
  end

  logic                    v2;
  logic signed [PIX_W-1:0] q2;
  logic [COL_W:0]          tag2;
  logic [COL_W-1:0]        col2;
  logic                    par2;

  requant_unit #(
    .TAG_W(COL_W + 1)
  ) u_requant (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pixel_in  (pixel_in),
    .mult      (mult),
    .shift     (shift),
    .tag_in    ({cur_par, cur_col}),
    .out_valid (v2),
    .q         (q2),
    .tag_out   (tag2)
  );

  always_comb begin
    par2 = tag2[COL_W];
    col2 = tag2[COL_W-1:0];
  end

  pool_pos_e               pos;
  logic [ADDR_W-1:0]       addr;
  logic signed [PIX_W-1:0] held, rd, win_top, win_all;
  logic signed [PIX_W-1:0] rowbuf [DEPTH];

  always_comb begin
    pos     = pool_pos_e'({par2, col2[0]});
    addr    = col2[COL_W-1:1];
    rd      = rowbuf[addr];
    win_top = smax(held, q2);
    win_all = smax(win_top, rd);
  end

  // Top-row pair max is parked here until the matching odd-row pair arrives.
  always_ff @(posedge clk) begin
    if (v2 && pool_en && pos == POS_TR) rowbuf[addr] <= win_top;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held      <= '0;
      out_valid <= 1'b0;
      pixel_out <= '0;
    end else if (!pool_en) begin
      out_valid <= v2;
      if (v2) pixel_out <= q2;
    end else begin
      out_valid <= v2 && (pos == POS_BR);
      if (v2) begin
        case (pos)
          POS_TL, POS_BL: held      <= q2;
          POS_BR:         pixel_out <= win_all;
          default:        ;
        endcase
      end
    end
  end

endmodule
